// File: rtl/riscv_fetch_queue_pkg.sv
// Shared constants, types and helpers for the instruction-fetch queue.
package riscv_fetch_queue_pkg;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam int          FETCH_DEPTH = 4;
    localparam logic [31:0] INST_BYTES  = 32'd4;

    typedef enum logic [1:0] {
        RESP_NONE   = 2'd0,
        RESP_DROP   = 2'd1,
        RESP_FILL   = 2'd2,
        RESP_ORPHAN = 2'd3
    } resp_kind_e;

    // Stale responses are always drained before any live slot is filled.
    function automatic resp_kind_e classify_resp(input logic rvalid,
                                                 input logic drop_pending,
                                                 input logic slot_pending);
        resp_kind_e kind;
        if (!rvalid) begin
            kind = RESP_NONE;
        end else if (drop_pending) begin
            kind = RESP_DROP;
        end else if (slot_pending) begin
            kind = RESP_FILL;
        end else begin
            kind = RESP_ORPHAN;
        end
        return kind;
    endfunction

endpackage

// File: rtl/riscv_fetch_buf.sv
// Circular PC/instruction store with reserve, fill and read pointers.
// Pointers carry an extra MSB so a full ring is distinguishable from an empty one.
module riscv_fetch_buf
    import riscv_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = FETCH_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int               PTR_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_inst,
    output logic [ADDR_W-1:0] head_pc,
    output logic [PTR_W-1:0]  reserved,
    output logic [PTR_W-1:0]  unfilled
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  rsv_ptr_r;
    logic [PTR_W-1:0]  fill_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [DEPTH-1:0]  filled_r;
    logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
    logic [DATA_W-1:0] inst_mem_r [DEPTH];

    logic [IDX_W-1:0]  rsv_idx_s;
    logic [IDX_W-1:0]  fill_idx_s;
    logic [IDX_W-1:0]  rd_idx_s;

    assign rsv_idx_s  = rsv_ptr_r[IDX_W-1:0];
    assign fill_idx_s = fill_ptr_r[IDX_W-1:0];
    assign rd_idx_s   = rd_ptr_r[IDX_W-1:0];

    // Pointer and filled-bit update; the three indices never collide when used.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rsv_ptr_r  <= '0;
            fill_ptr_r <= '0;
            rd_ptr_r   <= '0;
            filled_r   <= '0;
        end else begin
            if (push) begin
                rsv_ptr_r           <= rsv_ptr_r + PTR_W'(1'b1);
                filled_r[rsv_idx_s] <= 1'b0;
            end
            if (fill) begin
                fill_ptr_r           <= fill_ptr_r + PTR_W'(1'b1);
                filled_r[fill_idx_s] <= 1'b1;
            end
            if (pop) begin
                rd_ptr_r           <= rd_ptr_r + PTR_W'(1'b1);
                filled_r[rd_idx_s] <= 1'b0;
            end
        end
    end

    // Entry payload storage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= RESET_PC;
                inst_mem_r[i] <= DATA_W'(NOP_INST);
            end
        end else begin
            if (push) begin
                pc_mem_r[rsv_idx_s] <= push_pc;
            end
            if (fill) begin
                inst_mem_r[fill_idx_s] <= fill_data;
            end
        end
    end

    assign head_valid = filled_r[rd_idx_s];
    assign head_inst  = head_valid ? inst_mem_r[rd_idx_s] : DATA_W'(NOP_INST);
    assign head_pc    = pc_mem_r[rd_idx_s];
    assign reserved   = rsv_ptr_r - rd_ptr_r;
    assign unfilled   = rsv_ptr_r - fill_ptr_r;

endmodule

// File: rtl/riscv_fetch_queue_chk.sv
// Simulation-only protocol checks for the fetch queue memory interface.
module riscv_fetch_queue_chk #(
    parameter int PTR_W  = 3,
    parameter int DISC_W = 3
) (
    input logic              clk,
    input logic              rst,
    input logic              rvalid,
    input logic [DISC_W-1:0] discard,
    input logic [PTR_W-1:0]  unfilled
);

    // A response must either be owed to a flushed request or to a reserved slot.
    a_no_orphan_resp: assert property (
        @(posedge clk) disable iff (!rst)
        rvalid |-> ((discard != '0) || (unfilled != '0))
    );

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: in-order requests to variable-latency memory,
// buffered results for ID, and flush of buffered and in-flight fetches on redirect.
module riscv_fetch_queue
    import riscv_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = FETCH_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_o,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              gnt_i,
    input  logic              rvalid_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              id_stall_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o
);

    localparam int PTR_W  = $clog2(DEPTH) + 1;
    localparam int DISC_W = $clog2(DEPTH + 1);
    localparam int CNT_W  = $clog2(DEPTH) + 2;

    logic [ADDR_W-1:0] pc_r;
    logic [DISC_W-1:0] discard_r;

    logic [PTR_W-1:0]  reserved_s;
    logic [PTR_W-1:0]  unfilled_s;
    logic [CNT_W-1:0]  occupancy_s;
    logic [CNT_W-1:0]  flush_discard_s;
    logic              can_issue_s;
    logic              issue_s;
    logic              fill_s;
    logic              pop_s;
    resp_kind_e        resp_s;

    // Handshake decode. Occupancy counts flushed requests still owed a
    // response, so they keep holding capacity until they drain.
    always_comb begin
        occupancy_s = CNT_W'(reserved_s) + CNT_W'(discard_r);
        can_issue_s = (occupancy_s < CNT_W'(DEPTH));
        req_o       = rst && !flush_i && can_issue_s;
        issue_s     = req_o && gnt_i;
        resp_s      = classify_resp(rvalid_i, (discard_r != '0), (unfilled_s != '0));
        fill_s      = rst && !flush_i && (resp_s == RESP_FILL);
        pop_s       = rst && !flush_i && inst_valid_o && !id_stall_i;

        flush_discard_s = CNT_W'(unfilled_s) + CNT_W'(discard_r);
        if (gnt_i && can_issue_s) begin
            flush_discard_s = flush_discard_s + CNT_W'(1'b1);
        end else begin
            flush_discard_s = flush_discard_s;
        end
        case (resp_s)
            RESP_DROP, RESP_FILL: flush_discard_s = flush_discard_s - CNT_W'(1'b1);
            default:              flush_discard_s = flush_discard_s;
        endcase
    end

    // Fetch PC: redirect on flush, otherwise advance on each accepted request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r <= RESET_PC;
        end else if (flush_i) begin
            pc_r <= flush_pc_i;
        end else if (issue_s) begin
            pc_r <= pc_r + ADDR_W'(INST_BYTES);
        end else begin
            pc_r <= pc_r;
        end
    end

    // Count of responses still to be thrown away after a redirect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            discard_r <= '0;
        end else if (flush_i) begin
            discard_r <= flush_discard_s[DISC_W-1:0];
        end else if (resp_s == RESP_DROP) begin
            discard_r <= discard_r - DISC_W'(1'b1);
        end else begin
            discard_r <= discard_r;
        end
    end

    assign req_addr_o = pc_r;

    riscv_fetch_buf #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush_i),
        .push       (issue_s),
        .push_pc    (pc_r),
        .fill       (fill_s),
        .fill_data  (rdata_i),
        .pop        (pop_s),
        .head_valid (inst_valid_o),
        .head_inst  (inst_o),
        .head_pc    (pc_o),
        .reserved   (reserved_s),
        .unfilled   (unfilled_s)
    );

    riscv_fetch_queue_chk #(
        .PTR_W  (PTR_W),
        .DISC_W (DISC_W)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .rvalid   (rvalid_i),
        .discard  (discard_r),
        .unfilled (unfilled_s)
    );

endmodule
